spi_master_ctrl: RTL and testbench
==================================

# spi_master_ctrl

SPI master for the single-clock SPI slave/RAM wrapper. It converts host command requests (write-address, write-data, read-address, read-data) into complete SPI frames on SS_n/MOSI and, for read-data, captures the 8-bit response on MISO. The SPI bit clock is the shared system clock CLK, and both ends shift on rising edges. It serves as the bus-side driver in system-level benches and as the host-side front end in integration.

## Interface
- RD_WAIT, 2: cycles between the last MOSI bit and the first MISO sample in a read-data frame (≥1).
- GAP_CYCLES, 2: minimum cycles SS_n stays high between frames (≥1).
- CLK  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  host request strobe.
- req_ready  out  1  high only in IDLE; a request is accepted on an edge where req_valid && req_ready.
- req_cmd  in  2  00 write-addr, 01 write-data, 10 read-addr, 11 read-data.
- req_data  in  8  address or data byte; ignored content (dummy) for 11.
- rsp_valid  out  1  one-cycle pulse carrying read-data result.
- rsp_data  out  8  last received byte; holds until next read-data completes.
- busy  out  1  high in every state except IDLE.
- SS_n  out  1  slave select, active-low.
- MOSI  out  1  serial data to slave, MSB first.
- MISO  in  1  serial data from slave, MSB first.

## Operation
- States: IDLE, START, SEL, SHIFT, TURN, RECV, GAP.
- IDLE: SS_n=1, MOSI=0, req_ready=1. On accept, latch cmd and data into a shift register {cmd[1], cmd[0], data[7:0]}, then go to START.
- START: SS_n=0, MOSI=0. Holds one cycle so the slave can leave idle.
- SEL: MOSI=cmd[1]. This is the read/write select bit. Lasts 1 cycle.
- SHIFT: 10 cycles. MOSI=cmd[1], cmd[0], data[7]..data[0]. A 4-bit counter tracks the bits.
- After SHIFT: cmd≠11 goes to GAP. cmd=11 goes to TURN.
- TURN: RD_WAIT cycles, SS_n=0, MOSI=0.
- RECV: 8 cycles. MISO is shifted into rx[7:0] MSB first. After the 8th sample: rsp_data←rx, rsp_valid=1 for one cycle, then go to GAP.
- GAP: SS_n=1, MOSI=0 for GAP_CYCLES, then IDLE.
- req_valid outside IDLE is ignored. It is neither queued nor acknowledged.
- req_cmd/req_data changes after accept have no effect on the frame in flight.

## Timing
- Reset (asynchronous, any state): state=IDLE, SS_n=1, MOSI=0, rsp_valid=0, rsp_data=0x00, busy=0, counters=0. Reset mid-frame raises SS_n immediately, with no partial response.
- Edges are numbered from accept edge T0. All outputs are registered.
- SS_n: low after T0, through T12 for cmd≠11.
- MOSI: select bit after T1. Frame bits b9..b0 after T2..T11.
- cmd≠11: SS_n returns high after T12. The frame is 12 cycles with SS_n low.
- cmd=11: MISO is sampled at edges T(12+RD_WAIT+k), k=0..7.
  - k=0 is the MSB.
  - rsp_valid and SS_n=1 appear after T(20+RD_WAIT).
- Next accept is at the earliest T_end+GAP_CYCLES, where T_end is the edge SS_n rises.
- Back-to-back requests with req_valid held high: frames are separated by exactly GAP_CYCLES high cycles of SS_n.
- rsp_valid is never asserted for cmd 00/01/10.

## Test plan
- Reset defaults: assert rst mid-cycle with no clock edge. SS_n=1, MOSI=0, rsp_valid=0, rsp_data=0x00 and busy=0 appear immediately, and req_ready=1.
- Write-address: cmd=00, data=0xA5. MOSI after T1..T11 = 0,0,0,1,0,1,0,0,1,0,1. SS_n is low for exactly 12 cycles. No rsp_valid.
- Full RAM loop against the slave wrapper:
  - Write-address 0x3C, then write-data 0x5A.
  - Read-address 0x3C, then read-data.
  - Result: rsp_data=0x5A, one rsp_valid pulse.
- Read-data timing with the MISO model driving 0xC3 from edge T14, using default RD_WAIT=2: rsp_data=0xC3 and rsp_valid after T22, with SS_n rising on the same edge.
- Back-to-back: req_valid held with 3 queued commands. req_ready pulses once per frame, and SS_n is high for exactly 2 cycles between frames. A req_valid toggle during busy is ignored.
- Reset mid-frame: rst at T6 of a write-data. SS_n=1 at once and the FSM returns to IDLE. The next request produces a clean, complete frame.

Source files
------------

// File: rtl/spi_master_ctrl.sv
// SPI master: turns host write/read requests into SS_n/MOSI frames and captures read-data on MISO.
// Latency: write frames hold SS_n low 12 cycles; read-data returns rsp_valid 20+RD_WAIT edges after accept.
// Backpressure: req_ready is high only in IDLE; requests seen while busy are dropped, not queued.
module spi_master_ctrl #(
  parameter int RD_WAIT    = 2,
  parameter int GAP_CYCLES = 2
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_cmd,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    SEL,
    SHIFT,
    TURN,
    RECV,
    GAP
  } state_t;

  // TURN ends on the edge that takes the first MISO sample.
  localparam logic [7:0] TURN_LAST = 8'(RD_WAIT - 1);
  // The IDLE cycle counts as one of the SS_n-high gap cycles, so GAP itself is one shorter.
  localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 2);

  state_t     state;
  logic [9:0] shreg;     // {cmd[1], cmd[0], data[7:0]}, shifted out MSB first
  logic [1:0] cmd_q;
  logic [3:0] bit_cnt;   // bits sent in SHIFT, bits received in RECV
  logic [7:0] wait_cnt;  // cycles spent in TURN or GAP
  logic [7:0] rx;

  // Single FSM with all outputs registered alongside the state.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      cmd_q     <= '0;
      bit_cnt   <= '0;
      wait_cnt  <= '0;
      rx        <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      busy      <= 1'b0;
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          SS_n <= 1'b1;
          MOSI <= 1'b0;
          if (req_valid) begin
            shreg     <= {req_cmd, req_data};
            cmd_q     <= req_cmd;
            state     <= START;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            SS_n      <= 1'b0;
          end
        end

        START: begin
          // Select bit goes out one cycle ahead of the framed bits.
          MOSI  <= shreg[9];
          state <= SEL;
        end

        SEL: begin
          MOSI    <= shreg[9];
          shreg   <= {shreg[8:0], 1'b0};
          bit_cnt <= 4'd1;
          state   <= SHIFT;
        end

        SHIFT: begin
          if (bit_cnt == 4'd10) begin
            MOSI     <= 1'b0;
            bit_cnt  <= '0;
            wait_cnt <= '0;
            if (cmd_q == 2'b11) begin
              state <= TURN;
            end else begin
              SS_n <= 1'b1;
              if (GAP_CYCLES > 1) begin
                state <= GAP;
              end else begin
                state     <= IDLE;
                busy      <= 1'b0;
                req_ready <= 1'b1;
              end
            end
          end else begin
            MOSI    <= shreg[9];
            shreg   <= {shreg[8:0], 1'b0};
            bit_cnt <= bit_cnt + 4'd1;
          end
        end

        TURN: begin
          if (wait_cnt == TURN_LAST) begin
            // First (MSB) sample is taken on the edge that leaves TURN.
            rx      <= {rx[6:0], MISO};
            bit_cnt <= 4'd1;
            state   <= RECV;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        RECV: begin
          if (bit_cnt == 4'd8) begin
            rsp_data  <= rx;
            rsp_valid <= 1'b1;
            SS_n      <= 1'b1;
            bit_cnt   <= '0;
            wait_cnt  <= '0;
            if (GAP_CYCLES > 1) begin
              state <= GAP;
            end else begin
              state     <= IDLE;
              busy      <= 1'b0;
              req_ready <= 1'b1;
            end
          end else begin
            rx      <= {rx[6:0], MISO};
            bit_cnt <= bit_cnt + 4'd1;
          end
        end

        GAP: begin
          if (wait_cnt == GAP_LAST) begin
            wait_cnt  <= '0;
            state     <= IDLE;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          req_ready <= 1'b1;
          SS_n      <= 1'b1;
          MOSI      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: directed requests, a behavioural SPI RAM slave and a frame/response scoreboard.
// Stimulus pushes expected frames and read results; a negedge monitor pops and compares them.
// Every wait is bounded; the summary line is always reached.
module tb_spi_master_ctrl;

  localparam int RD_WAIT = 2;
  localparam int GAP_CYCLES = 2;

  logic       CLK = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_cmd = 2'b00;
  logic [7:0] req_data = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       SS_n;
  logic       MOSI;
  logic       MISO = 1'b0;

  spi_master_ctrl #(.RD_WAIT(RD_WAIT), .GAP_CYCLES(GAP_CYCLES)) dut (
    .CLK      (CLK),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_cmd  (req_cmd),
    .req_data (req_data),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .busy     (busy),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [11:0] word;   // MOSI seen after T0..T11, first bit in word[11]
    int          len;    // cycles with SS_n low
    int          gap;    // required SS_n-high cycles before this frame, 0 = unchecked
    bit          abort;  // frame is killed by reset; discard
  } frm_t;

  frm_t       fq[$];
  logic [7:0] rq[$];
  int         total = 0;
  int         bad = 0;
  int         acc_cnt = 0;
  int         exp_acc = 0;

  // slave / monitor state
  int          low_cnt = 0;
  int          high_cnt = 0;
  int          extra = 0;
  logic [11:0] cap = '0;
  logic [1:0]  cur_cmd = '0;
  logic [7:0]  waddr = '0;
  logic [7:0]  raddr = '0;
  logic [7:0]  rd_byte = '0;
  logic [7:0]  mem [256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Accepted handshakes, counted like a flop would see them.
  always @(posedge CLK) begin
    if (!rst && req_valid && req_ready) acc_cnt <= acc_cnt + 1;
  end

  // Monitor + RAM slave: frames are captured and checked on the falling edge.
  always @(negedge CLK) begin
    if (rst) begin
      if (low_cnt > 0 && fq.size() > 0 && fq[0].abort) void'(fq.pop_front());
      low_cnt = 0;
      high_cnt = 0;
      extra = 0;
      MISO = 1'b0;
    end else begin
      if (rsp_valid) begin
        if (rq.size() == 0) begin
          chk("unexpected_rsp", 32'(rsp_data), 32'hFFFF_FFFF);
        end else begin
          chk("rsp_data", 32'(rsp_data), 32'(rq.pop_front()));
          chk("rsp_ss_n_high", 32'(SS_n), 32'd1);
          chk("rsp_latency", 32'(low_cnt), 32'(20 + RD_WAIT));
        end
      end
      if (!SS_n) begin
        if (low_cnt == 0) begin
          if (fq.size() == 0) chk("unexpected_frame", 32'(low_cnt), 32'hFFFF_FFFF);
          else if (fq[0].gap != 0) chk("gap_cycles", 32'(high_cnt), 32'(fq[0].gap));
        end
        if (low_cnt < 12) cap[11-low_cnt] = MOSI;
        else if (MOSI) extra++;
        if (low_cnt == 11) begin
          cur_cmd = cap[9:8];
          case (cap[9:8])
            2'b00: waddr = cap[7:0];
            2'b01: mem[waddr] = cap[7:0];
            2'b10: raddr = cap[7:0];
            default: rd_byte = mem[raddr];
          endcase
        end
        if (cur_cmd == 2'b11 && low_cnt >= 11 + RD_WAIT && low_cnt <= 18 + RD_WAIT)
          MISO = rd_byte[7-(low_cnt-11-RD_WAIT)];
        else
          MISO = 1'b0;
        low_cnt++;
      end else begin
        if (low_cnt > 0) begin
          if (fq.size() > 0) begin
            chk("frame_bits", 32'(cap), 32'(fq[0].word));
            chk("frame_len", 32'(low_cnt), 32'(fq[0].len));
            chk("mosi_idle_zero", 32'(extra), 32'd0);
            void'(fq.pop_front());
          end
          low_cnt = 0;
          extra = 0;
          high_cnt = 1;
          MISO = 1'b0;
          cur_cmd = 2'b00;
        end else begin
          high_cnt++;
        end
      end
    end
  end

  // Issue one request; hold keeps req_valid high after the accept for back-to-back use.
  task automatic send(input logic [1:0] cmd, input logic [7:0] data, input logic [11:0] word,
                      input int len, input int gap, input bit abort, input bit hold,
                      input logic [7:0] exp_rsp);
    frm_t f;
    bit   ok;
    f.word = word;
    f.len = len;
    f.gap = gap;
    f.abort = abort;
    fq.push_back(f);
    if (cmd == 2'b11 && !abort) rq.push_back(exp_rsp);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("req_ready_timeout", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_cmd = cmd;
    req_data = data;
    @(posedge CLK);
    #1;
    exp_acc++;
    if (!hold) req_valid = 1'b0;
    // Scramble inputs after accept; the frame in flight must not change.
    req_cmd = ~cmd;
    req_data = ~data;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      if (fq.size() == 0 && rq.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("drain_timeout", 32'(fq.size() + rq.size()), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // Reset defaults, asserted between clock edges.
    #3 rst = 1'b1;
    #1;
    chk("rst_ss_n", 32'(SS_n), 32'd1);
    chk("rst_mosi", 32'(MOSI), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    #8 rst = 1'b0;
    repeat (2) @(posedge CLK);

    // Write-address 0xA5: MOSI 0,0,0,1,0,1,0,0,1,0,1 after T1..T11.
    send(2'b00, 8'hA5, 12'h0A5, 12, 0, 1'b0, 1'b0, 8'h00);
    drain();

    // RAM loop: write 0x5A to 0x3C and read it back.
    send(2'b00, 8'h3C, 12'h03C, 12, 0, 1'b0, 1'b0, 8'h00);
    send(2'b01, 8'h5A, 12'h15A, 12, 0, 1'b0, 1'b0, 8'h00);
    send(2'b10, 8'h3C, 12'h63C, 12, 0, 1'b0, 1'b0, 8'h00);
    send(2'b11, 8'h00, 12'h700, 20 + RD_WAIT, 0, 1'b0, 1'b0, 8'h5A);
    drain();

    // Read-data timing: slave returns 0xC3, rsp_valid with SS_n rising after T22.
    mem[8'h77] = 8'hC3;
    send(2'b10, 8'h77, 12'h677, 12, 0, 1'b0, 1'b0, 8'h00);
    send(2'b11, 8'hFF, 12'h7FF, 20 + RD_WAIT, 0, 1'b0, 1'b0, 8'hC3);
    drain();

    // rsp_data holds across a non-read frame.
    send(2'b00, 8'h3C, 12'h03C, 12, 0, 1'b0, 1'b0, 8'h00);
    drain();
    chk("rsp_data_hold", 32'(rsp_data), 32'hC3);

    // Back-to-back with req_valid held: exactly GAP_CYCLES high between frames.
    send(2'b01, 8'hE7, 12'h1E7, 12, 0, 1'b0, 1'b1, 8'h00);
    send(2'b00, 8'h42, 12'h042, 12, GAP_CYCLES, 1'b0, 1'b1, 8'h00);
    send(2'b10, 8'h81, 12'h681, 12, GAP_CYCLES, 1'b0, 1'b0, 8'h00);
    drain();
    chk("b2b_mem_write", 32'(mem[8'h3C]), 32'hE7);

    // req_valid toggling while busy is ignored.
    send(2'b00, 8'h11, 12'h011, 12, 0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      req_valid = ~req_valid;
      req_cmd = 2'b11;
      req_data = 8'h66;
    end
    req_valid = 1'b0;
    drain();

    // Reset at T6 of a write-data frame, then a clean frame.
    send(2'b01, 8'h99, 12'h199, 12, 0, 1'b1, 1'b0, 8'h00);
    repeat (6) @(posedge CLK);
    #2 rst = 1'b1;
    #1;
    chk("midrst_ss_n", 32'(SS_n), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    chk("midrst_mosi", 32'(MOSI), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    #9 rst = 1'b0;
    send(2'b00, 8'h0F, 12'h00F, 12, 0, 1'b0, 1'b0, 8'h00);
    drain();

    repeat (4) @(negedge CLK);
    chk("frames_left", 32'(fq.size()), 32'd0);
    chk("rsp_left", 32'(rq.size()), 32'd0);
    chk("accept_count", 32'(acc_cnt), 32'(exp_acc));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
